opnd_fetch_ctrl: RTL and testbench
==================================

// Module: opnd_fetch_ctrl
// PURPOSE
//  Sequencer between operand decode and execute. Takes one decoded operand bundle
//  (register values plus effective-address components), computes the EA, and
//  runs one memory read when an operand is memory-sourced. Substitutes the size-masked
//  read data into the selected operand slot, then hands the bundle to execute.
// PARAMETERS
//  WAIT_LIMIT  255  max cycles in WAIT for mem_rsp_valid before abort (1..65535)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  in_valid       in   1   decoded bundle valid
//  in_ready       out  1   bundle accepted when in_valid & in_ready
//  in_opnd0       in   32  operand#0 register value
//  in_opnd1       in   32  operand#1 register value
//  in_mem_sel     in   2   `OPND_MEM_NONE=0, `OPND_MEM_OPND0=1, `OPND_MEM_OPND1=2, 3=reserved
//  in_base        in   32  base register value (0 if none)
//  in_index       in   32  index register value (0 if none)
//  in_scale       in   2   SIB scale, shift amount 0..3
//  in_disp        in   32  sign-extended displacement
//  in_addr16      in   1   16-bit address-size prefix
//  in_size        in   2   `OPND_SZ_8=0, `OPND_SZ_16=1, `OPND_SZ_32=2
//  mem_req_valid  out  1   read request valid
//  mem_req_ready  in   1   read request accepted
//  mem_req_addr   out  32  read address
//  mem_rsp_valid  in   1   read data valid
//  mem_rsp_data   in   32  read data
//  out_valid      out  1   resolved bundle valid
//  out_ready      in   1   execute consumes bundle
//  out_opnd0      out  32  resolved operand#0
//  out_opnd1      out  32  resolved operand#1
//  out_addr       out  32  EA used (0 when no memory operand)
//  out_err        out  1   reserved in_mem_sel or WAIT timeout
// BEHAVIOUR
//  States: IDLE -> CALC -> REQ -> WAIT -> OUT -> IDLE.
//  No-memory path: IDLE -> OUT.
//  Reset: state=IDLE. in_ready=1. All other outputs 0. Wait counter=0.
//  IDLE: in_ready=1.
//   - On accept, register all in_* fields.
//   - in_mem_sel==NONE: go to OUT.
//   - in_mem_sel==3: go to OUT with out_err=1 and operands passed through.
//   - Otherwise go to CALC.
//  CALC (1 cycle): ea = in_base + (in_index << in_scale) + in_disp, mod 2^32.
//   - If in_addr16, ea[31:16]=0 (16-bit wrap).
//   - Register ea, go to REQ.
//  REQ: mem_req_valid=1 and mem_req_addr=ea, both held stable until mem_req_ready.
//   - On handshake go to WAIT and clear the counter.
//  WAIT: mem_rsp_valid is sampled only in this state and ignored in all others.
//   - Counter increments each cycle without a response.
//   - On rsp: data masked to in_size and zero-extended, written to the selected slot; go to OUT.
//   - Rsp in the same cycle the counter reaches WAIT_LIMIT: rsp wins, out_err=0.
//   - Counter == WAIT_LIMIT with no rsp: slot=0, out_err=1, go to OUT.
//  OUT: out_valid=1 with all out_* stable until out_ready. Then go to IDLE.
//   - in_ready=0 in every state except IDLE.
//  Latency from accept to out_valid: no-mem 1 cycle; mem 3 cycles + req stall + rsp wait.
//  rst in any state aborts: mem_req_valid drops the same edge. A late rsp is ignored.
// STRUCTURE
//  Shared defines.v gains OPND_MEM_* and OPND_SZ_* codes and the FSM state encodings.
//  Sub-module ea_calc: combinational base/index/scale/disp adder with addr16 truncation.
//  Masking and FSM stay in this module.
// TESTING
//  1. mem_sel=0, opnd0=0x11, opnd1=0x22 -> out_valid 1 cycle later; 0x11/0x22; addr=0; no mem_req.
//  2. mem_sel=1, base=0x1000, index=4, scale=2, disp=-8, size=32, ready=1, rsp 0xDEADBEEF after 2 cycles
//     -> mem_req_addr=0x1008; out_opnd0=0xDEADBEEF; opnd1 passthrough.
//  3. addr16=1, base=0xFFF0, disp=0x20, mem_sel=2, size=8, rsp=0xAABBCCDD
//     -> addr=0x00000010; out_opnd1=0x000000DD.
//  4. mem_req_ready low 5 cycles -> req valid/addr stable for 6 cycles; then out_ready low 3 cycles
//     -> out_* stable; in_ready=0 throughout.
//  5. WAIT_LIMIT=4, no rsp -> out_err=1 and slot=0 after 4 cycles. Rsp exactly at cycle 4 -> data taken, err=0.
//  6. rst in WAIT -> next cycle IDLE, all outputs 0; subsequent stray rsp ignored; next bundle processed correctly.

Source files
------------

// File: rtl/opnd_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// opnd_fetch_ctrl_pkg
//   Shared codes for the operand-fetch sequencer: memory-operand selector,
//   operand size, FSM state encodings, the registered effective-address
//   context and the read-data size mask.
// ---------------------------------------------------------------------------
package opnd_fetch_ctrl_pkg;

    // Which operand slot (if any) is sourced from memory.
    localparam logic [1:0] OPND_MEM_NONE  = 2'd0;
    localparam logic [1:0] OPND_MEM_OPND0 = 2'd1;
    localparam logic [1:0] OPND_MEM_OPND1 = 2'd2;
    localparam logic [1:0] OPND_MEM_RSVD  = 2'd3;

    // Operand size codes; the unused code 3 is treated as full width.
    localparam logic [1:0] OPND_SZ_8  = 2'd0;
    localparam logic [1:0] OPND_SZ_16 = 2'd1;
    localparam logic [1:0] OPND_SZ_32 = 2'd2;

    // Sequencer state encodings.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    // Fields of the accepted bundle still needed after the accept cycle.
    typedef struct packed {
        logic [1:0]  mem_sel;
        logic [1:0]  size;
        logic [31:0] base;
        logic [31:0] index;
        logic [1:0]  scale;
        logic [31:0] disp;
        logic        addr16;
    } opnd_ctx_t;

    // Keep only the low bytes selected by the operand size, zero-extended.
    function automatic logic [31:0] size_mask(input logic [31:0] data,
                                              input logic [1:0]  size);
        case (size)
            OPND_SZ_8:  return {24'h000000, data[7:0]};
            OPND_SZ_16: return {16'h0000, data[15:0]};
            default:    return data;
        endcase
    endfunction

endpackage

// File: rtl/opnd_fetch_ctrl_ea_calc.sv
// ---------------------------------------------------------------------------
// opnd_fetch_ctrl_ea_calc
//   Combinational effective-address adder: base + (index << scale) + disp,
//   modulo 2^32, with the upper half cleared for 16-bit address size.
// Ports
//   base    in  32  base register value
//   index   in  32  index register value
//   scale   in   2  index shift amount 0..3
//   disp    in  32  sign-extended displacement
//   addr16  in   1  16-bit address size: wrap the result at 64 KiB
//   ea      out 32  effective address
// ---------------------------------------------------------------------------
module opnd_fetch_ctrl_ea_calc (
    input  logic [31:0] base,
    input  logic [31:0] index,
    input  logic [1:0]  scale,
    input  logic [31:0] disp,
    input  logic        addr16,
    output logic [31:0] ea
);

    logic [31:0] full_sum;

    // NOTE: every signal written in always_comb is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        full_sum = base + (index << scale) + disp;
        ea       = addr16 ? {16'h0000, full_sum[15:0]} : full_sum;
    end

endmodule

// File: rtl/opnd_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// opnd_fetch_ctrl
//   Sequencer between operand decode and execute. Accepts one decoded bundle,
//   computes the effective address, performs one memory read when an operand
//   is memory-sourced, substitutes the size-masked read data into the
//   selected slot and presents the resolved bundle to execute.
// Parameters
//   WAIT_LIMIT  maximum WAIT cycles without a response before abort (1..65535)
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   in_valid / in_ready         decoded bundle handshake
//   in_opnd0, in_opnd1          register operand values
//   in_mem_sel                  memory-sourced slot (none/opnd0/opnd1/reserved)
//   in_base, in_index, in_scale, in_disp, in_addr16   EA components
//   in_size                     operand size for read-data masking
//   mem_req_valid/ready/addr    read request channel
//   mem_rsp_valid/data          read response channel
//   out_valid / out_ready       resolved bundle handshake
//   out_opnd0, out_opnd1        resolved operands
//   out_addr                    EA used (0 without a memory operand)
//   out_err                     reserved selector or response timeout
// ---------------------------------------------------------------------------
module opnd_fetch_ctrl
    import opnd_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_opnd0,
    input  logic [31:0] in_opnd1,
    input  logic [1:0]  in_mem_sel,
    input  logic [31:0] in_base,
    input  logic [31:0] in_index,
    input  logic [1:0]  in_scale,
    input  logic [31:0] in_disp,
    input  logic        in_addr16,
    input  logic [1:0]  in_size,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_opnd0,
    output logic [31:0] out_opnd1,
    output logic [31:0] out_addr,
    output logic        out_err
);

    // Timeout fires on the WAIT cycle in which the counter reaches WAIT_LIMIT.
    localparam logic [15:0] LAST_WAIT = 16'(WAIT_LIMIT - 1);

    logic [2:0]  state;
    opnd_ctx_t   ctx_q;
    logic [31:0] res0_q;
    logic [31:0] res1_q;
    logic [31:0] addr_q;
    logic        err_q;
    logic [15:0] wait_cnt;

    logic [31:0] ea;
    logic [31:0] rsp_masked;
    logic        is_mem_sel;

    opnd_fetch_ctrl_ea_calc u_ea_calc (
        .base   (ctx_q.base),
        .index  (ctx_q.index),
        .scale  (ctx_q.scale),
        .disp   (ctx_q.disp),
        .addr16 (ctx_q.addr16),
        .ea     (ea)
    );

    assign rsp_masked = size_mask(mem_rsp_data, ctx_q.size);
    assign is_mem_sel = (in_mem_sel == OPND_MEM_OPND0) || (in_mem_sel == OPND_MEM_OPND1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ctx_q    <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ctx_q.mem_sel <= in_mem_sel;
                        ctx_q.size    <= in_size;
                        ctx_q.base    <= in_base;
                        ctx_q.index   <= in_index;
                        ctx_q.scale   <= in_scale;
                        ctx_q.disp    <= in_disp;
                        ctx_q.addr16  <= in_addr16;
                        res0_q        <= in_opnd0;
                        res1_q        <= in_opnd1;
                        addr_q        <= '0;
                        err_q         <= (in_mem_sel == OPND_MEM_RSVD);
                        wait_cnt      <= '0;
                        // Reserved selector takes the no-memory path with error.
                        state         <= is_mem_sel ? ST_CALC : ST_OUT;
                    end
                end
                ST_CALC: begin
                    addr_q <= ea;
                    state  <= ST_REQ;
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response on the final allowed cycle still wins.
                    if (mem_rsp_valid) begin
                        if (ctx_q.mem_sel == OPND_MEM_OPND0) res0_q <= rsp_masked;
                        else                                 res1_q <= rsp_masked;
                        state <= ST_OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == LAST_WAIT) begin
                            if (ctx_q.mem_sel == OPND_MEM_OPND0) res0_q <= '0;
                            else                                 res1_q <= '0;
                            err_q <= 1'b1;
                            state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and gated so that everything except
    // in_ready reads zero outside its active state.
    assign in_ready      = (state == ST_IDLE);
    assign mem_req_valid = (state == ST_REQ);
    assign mem_req_addr  = mem_req_valid ? addr_q : '0;
    assign out_valid     = (state == ST_OUT);
    assign out_opnd0     = out_valid ? res0_q : '0;
    assign out_opnd1     = out_valid ? res1_q : '0;
    assign out_addr      = out_valid ? addr_q : '0;
    assign out_err       = out_valid & err_q;

endmodule

// File: tb/tb_opnd_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_opnd_fetch_ctrl
//   Directed bench for opnd_fetch_ctrl. A per-bundle model computes the
//   resolved result from the EA/masking/timeout rules; a compare process
//   checks request and result outputs every cycle they are valid.
// ---------------------------------------------------------------------------
module tb_opnd_fetch_ctrl;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_opnd0, in_opnd1, in_base, in_index, in_disp;
    logic [1:0]  in_mem_sel, in_scale, in_size;
    logic        in_addr16;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_opnd0, out_opnd1, out_addr;
    logic        out_err;

    always #5 clk = ~clk;

    opnd_fetch_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opnd0      (in_opnd0),
        .in_opnd1      (in_opnd1),
        .in_mem_sel    (in_mem_sel),
        .in_base       (in_base),
        .in_index      (in_index),
        .in_scale      (in_scale),
        .in_disp       (in_disp),
        .in_addr16     (in_addr16),
        .in_size       (in_size),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opnd0     (out_opnd0),
        .out_opnd1     (out_opnd1),
        .out_addr      (out_addr),
        .out_err       (out_err)
    );

    typedef struct {
        logic [31:0] opnd0, opnd1;
        logic [1:0]  sel;
        logic [31:0] base, index;
        logic [1:0]  scale;
        logic [31:0] disp;
        logic        addr16;
        logic [1:0]  size;
    } bundle_t;

    typedef struct {
        logic [31:0] o0, o1, addr;
        logic        err;
    } result_t;

    int          checks   = 0;
    int          failures = 0;
    result_t     exp_q[$];
    bit          req_expected = 1'b0;
    logic [31:0] exp_req_addr = '0;
    logic [31:0] seen_req_addr = '0;
    result_t     seen_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bundle_t mk(input logic [31:0] opnd0, input logic [31:0] opnd1,
                                   input logic [1:0] sel, input logic [31:0] base,
                                   input logic [31:0] index, input logic [1:0] scale,
                                   input logic [31:0] disp, input logic addr16,
                                   input logic [1:0] size);
        bundle_t b;
        b.opnd0 = opnd0; b.opnd1 = opnd1; b.sel = sel; b.base = base;
        b.index = index; b.scale = scale; b.disp = disp; b.addr16 = addr16;
        b.size = size;
        return b;
    endfunction

    // Compare process: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_req_valid) begin
                check("req_while_expected", {31'b0, req_expected}, 32'd1);
                check("req_addr", mem_req_addr, exp_req_addr);
                check("in_ready_during_req", {31'b0, in_ready}, 32'd0);
                seen_req_addr = mem_req_addr;
            end
            if (out_valid) begin
                check("out_queue_depth", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    check("out_opnd0", out_opnd0, exp_q[0].o0);
                    check("out_opnd1", out_opnd1, exp_q[0].o1);
                    check("out_addr", out_addr, exp_q[0].addr);
                    check("out_err", {31'b0, out_err}, {31'b0, exp_q[0].err});
                    check("in_ready_during_out", {31'b0, in_ready}, 32'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
                seen_out.o0   = out_opnd0;
                seen_out.o1   = out_opnd1;
                seen_out.addr = out_addr;
                seen_out.err  = out_err;
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
        check({tag, "_req_addr"}, mem_req_addr, 32'd0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_out_opnd0"}, out_opnd0, 32'd0);
        check({tag, "_out_opnd1"}, out_opnd1, 32'd0);
        check({tag, "_out_addr"}, out_addr, 32'd0);
        check({tag, "_out_err"}, {31'b0, out_err}, 32'd0);
    endtask

    task automatic drive_bundle(input bundle_t b);
        in_opnd0 = b.opnd0; in_opnd1 = b.opnd1; in_mem_sel = b.sel;
        in_base = b.base; in_index = b.index; in_scale = b.scale;
        in_disp = b.disp; in_addr16 = b.addr16; in_size = b.size;
        in_valid = 1'b1;
    endtask

    task automatic scramble_inputs();
        in_valid = 1'b0;
        in_opnd0 = 32'hBAD0BAD0; in_opnd1 = 32'hBAD1BAD1; in_mem_sel = 2'd3;
        in_base = 32'h0BADF00D; in_index = 32'h7777; in_scale = 2'd3;
        in_disp = 32'h1234; in_addr16 = 1'b0; in_size = 2'd2;
    endtask

    // rsp_k: WAIT cycle (1-based) on which the response is presented; 0 = never.
    task automatic run_txn(input string tag, input bundle_t b, input int req_stall,
                           input int rsp_k, input logic [31:0] rsp_data, input int out_stall);
        result_t     r;
        bit          is_mem, rsp_in_time;
        int          exp_k, lat, k;
        logic [31:0] ea, mask, val;

        is_mem      = (b.sel == 2'd1) || (b.sel == 2'd2);
        rsp_in_time = (rsp_k >= 1) && (rsp_k <= LIMIT);
        exp_k       = rsp_in_time ? rsp_k : LIMIT;
        ea = b.base + (b.index * (32'd1 << b.scale)) + b.disp;
        if (b.addr16) ea = ea % 32'h0001_0000;
        mask = (b.size == 2'd0) ? 32'hFF : (b.size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        r.o0 = b.opnd0; r.o1 = b.opnd1; r.addr = 32'd0; r.err = (b.sel == 2'd3);
        if (is_mem) begin
            r.addr = ea;
            val    = rsp_in_time ? (rsp_data & mask) : 32'd0;
            r.err  = !rsp_in_time;
            if (b.sel == 2'd1) r.o0 = val;
            else               r.o1 = val;
        end
        exp_q.push_back(r);
        req_expected = is_mem;
        exp_req_addr = ea;

        check({tag, "_in_ready_before"}, {31'b0, in_ready}, 32'd1);
        drive_bundle(b);
        step();
        scramble_inputs();
        lat = 1;
        k   = 0;
        if (is_mem) begin
            check({tag, "_calc_no_req"}, {31'b0, mem_req_valid}, 32'd0);
            check({tag, "_calc_in_ready"}, {31'b0, in_ready}, 32'd0);
            step(); lat++;
            check({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd1);
            for (int i = 0; i < req_stall; i++) begin
                step(); lat++;
                check({tag, "_req_held"}, {31'b0, mem_req_valid}, 32'd1);
            end
            mem_req_ready = 1'b1;
            step(); lat++;
            mem_req_ready = 1'b0;
            check({tag, "_req_dropped"}, {31'b0, mem_req_valid}, 32'd0);
            for (k = 1; k <= LIMIT + 2; k++) begin
                mem_rsp_valid = (k == rsp_k);
                mem_rsp_data  = rsp_data;
                step(); lat++;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = 32'h0;
                if (out_valid) break;
            end
            check({tag, "_wait_cycles"}, k, exp_k);
        end
        check({tag, "_latency"}, lat, is_mem ? (3 + req_stall + exp_k) : 1);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        if (out_valid) begin
            for (int i = 0; i < out_stall; i++) begin
                step();
                check({tag, "_out_held"}, {31'b0, out_valid}, 32'd1);
                check({tag, "_in_ready_stall"}, {31'b0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check({tag, "_out_done"}, {31'b0, out_valid}, 32'd0);
            check({tag, "_back_idle"}, {31'b0, in_ready}, 32'd1);
        end else begin
            exp_q.delete();
        end
        req_expected = 1'b0;
    endtask

    // Accept a memory bundle and reset it mid-flight in the given state.
    task automatic reset_midflight(input string tag, input bit in_wait);
        req_expected = 1'b1;
        exp_req_addr = 32'h0000_2000;
        drive_bundle(mk(32'h1, 32'h2, 2'd1, 32'h2000, 32'h0, 2'd0, 32'h0, 1'b0, 2'd2));
        step();
        scramble_inputs();
        step();
        check({tag, "_req_before_rst"}, {31'b0, mem_req_valid}, 32'd1);
        if (in_wait) begin
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        check_idle_zero(tag);
        rst = 1'b0;
        req_expected = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        out_ready     = 1'b0;
        scramble_inputs();
        repeat (3) step();
        check_idle_zero("reset");
        rst = 1'b0;
        step();

        // 1: no memory operand.
        run_txn("t1", mk(32'h11, 32'h22, 2'd0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 2'd2),
                0, 0, 32'h0, 0);
        check("t1_lit_opnd0", seen_out.o0, 32'h0000_0011);
        check("t1_lit_opnd1", seen_out.o1, 32'h0000_0022);
        check("t1_lit_addr", seen_out.addr, 32'h0);

        // 2: SIB address, 32-bit read into opnd0, response on WAIT cycle 2.
        run_txn("t2", mk(32'h55, 32'h66, 2'd1, 32'h1000, 32'h4, 2'd2, 32'hFFFF_FFF8, 1'b0, 2'd2),
                0, 2, 32'hDEAD_BEEF, 0);
        check("t2_lit_req_addr", seen_req_addr, 32'h0000_1008);
        check("t2_lit_opnd0", seen_out.o0, 32'hDEAD_BEEF);
        check("t2_lit_opnd1", seen_out.o1, 32'h0000_0066);

        // 3: 16-bit wrap, byte read into opnd1.
        run_txn("t3", mk(32'h77, 32'h88, 2'd2, 32'hFFF0, 32'h0, 2'd0, 32'h20, 1'b1, 2'd0),
                0, 1, 32'hAABB_CCDD, 0);
        check("t3_lit_addr", seen_out.addr, 32'h0000_0010);
        check("t3_lit_opnd1", seen_out.o1, 32'h0000_00DD);

        // Reserved selector: pass-through with error.
        run_txn("rsvd", mk(32'h1234, 32'h5678, 2'd3, 32'h100, 32'h0, 2'd0, 32'h0, 1'b0, 2'd2),
                0, 0, 32'h0, 0);
        check("rsvd_lit_err", {31'b0, seen_out.err}, 32'd1);

        // 4: request stalled 5 cycles, result stalled 3 cycles, 16-bit read.
        run_txn("t4", mk(32'hA0, 32'hB0, 2'd2, 32'h40, 32'h3, 2'd3, 32'h4, 1'b0, 2'd1),
                5, 3, 32'h1234_5678, 3);
        check("t4_lit_addr", seen_out.addr, 32'h0000_005C);
        check("t4_lit_opnd1", seen_out.o1, 32'h0000_5678);

        // 5a: no response -> timeout after LIMIT WAIT cycles.
        run_txn("t5a", mk(32'hCC, 32'hDD, 2'd1, 32'h300, 32'h0, 2'd0, 32'h0, 1'b0, 2'd2),
                0, 0, 32'h0, 0);
        check("t5a_lit_err", {31'b0, seen_out.err}, 32'd1);
        check("t5a_lit_slot", seen_out.o0, 32'h0);
        // 5b: response on the last allowed WAIT cycle wins.
        run_txn("t5b", mk(32'hCC, 32'hDD, 2'd2, 32'h304, 32'h0, 2'd0, 32'h0, 1'b0, 2'd2),
                0, LIMIT, 32'hCAFE_F00D, 0);
        check("t5b_lit_err", {31'b0, seen_out.err}, 32'd0);
        check("t5b_lit_slot", seen_out.o1, 32'hCAFE_F00D);

        // 6: reset in REQ and in WAIT, stray response, then a clean bundle.
        reset_midflight("rst_req", 1'b0);
        reset_midflight("rst_wait", 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFF_FFFF;
        step();
        mem_rsp_valid = 1'b0;
        check("stray_rsp_out_valid", {31'b0, out_valid}, 32'd0);
        check("stray_rsp_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("stray_rsp_still_idle", {31'b0, out_valid}, 32'd0);
        run_txn("t6", mk(32'h9, 32'hA, 2'd1, 32'h8000, 32'h10, 2'd1, 32'h0, 1'b0, 2'd1),
                1, 1, 32'h1357_9BDF, 1);
        check("t6_lit_addr", seen_out.addr, 32'h0000_8020);
        check("t6_lit_opnd0", seen_out.o0, 32'h0000_9BDF);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
